// File: rtl/everloop_tx.sv
// Everloop frame-buffer reader: fetches N_BYTES colour bytes from RAM and drives a
// WS2812/SK6812-style single-wire LED line, closing each frame with a low latch gap.
module everloop_tx #(
  parameter int N_BYTES = 140,
  parameter int T_BIT   = 62,
  parameter int T0H     = 18,
  parameter int T1H     = 35,
  parameter int T_RESET = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] ram_addr,
  output logic       ram_rd,
  input  logic [7:0] ram_data,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] BIT_END = CW'(T_BIT - 1);
  localparam logic [CW-1:0] RST_END = CW'(T_RESET - 1);
  localparam logic [CW-1:0] T0H_C   = CW'(T0H);
  localparam logic [CW-1:0] T1H_C   = CW'(T1H);
  localparam logic [7:0]    LAST_IDX = 8'(N_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_BIT, S_LATCH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_idx_q, byte_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    next_byte_q, next_byte_d;
  logic [7:0]    ram_addr_q, ram_addr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic cell_end, last_byte, prefetch;

  assign cell_end  = (cnt_q == BIT_END);
  assign last_byte = (byte_idx_q == LAST_IDX);
  assign prefetch  = (state_q == S_BIT) && (bit_idx_q == 3'd0) && !last_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      byte_idx_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      next_byte_q  <= '0;
      ram_addr_q   <= '0;
      ram_rd_q     <= 1'b0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_idx_q   <= byte_idx_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      next_byte_q  <= next_byte_d;
      ram_addr_q   <= ram_addr_d;
      ram_rd_q     <= ram_rd_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_BIT;
      S_BIT:   if (cell_end && bit_idx_q == 3'd0 && last_byte) state_d = S_LATCH;
      S_LATCH: if (cnt_q == RST_END) state_d = en ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so each lags its state by one cycle.
  always_comb begin
    cnt_d        = cnt_q;
    byte_idx_d   = byte_idx_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    next_byte_d  = next_byte_q;
    ram_addr_d   = ram_addr_q;
    ram_rd_d     = 1'b0;
    dout_d       = 1'b0;
    busy_d       = (state_q != S_IDLE);
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        byte_idx_d = '0;
      end
      S_FETCH: begin
        ram_rd_d   = 1'b1;
        ram_addr_d = byte_idx_q;
      end
      S_LOAD: begin
        shift_d   = ram_data;
        bit_idx_d = 3'd7;
        cnt_d     = '0;
      end
      S_BIT: begin
        dout_d = (cnt_q < (shift_q[7] ? T1H_C : T0H_C));
        // The next byte is fetched during the last bit cell so bytes abut seamlessly.
        if (prefetch && cnt_q == '0) begin
          ram_rd_d   = 1'b1;
          ram_addr_d = byte_idx_q + 8'd1;
        end
        if (prefetch && cnt_q == CW'(1)) next_byte_d = ram_data;
        if (cell_end) begin
          cnt_d = '0;
          if (bit_idx_q != 3'd0) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q - 3'd1;
          end else if (!last_byte) begin
            shift_d    = next_byte_q;
            byte_idx_d = byte_idx_q + 8'd1;
            bit_idx_d  = 3'd7;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == RST_END) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          byte_idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_everloop_tx.sv
// Directed bench for everloop_tx with a falling-edge RAM model and a negedge
// line monitor that records dout pulses, RAM reads, frame_done and busy edges.
module tb_everloop_tx;

  localparam int N_BYTES = 4;
  localparam int T_BIT   = 10;
  localparam int T0H     = 3;
  localparam int T1H     = 6;
  localparam int T_RESET = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] ram_addr;
  logic       ram_rd;
  logic [7:0] ram_data = 8'h00;
  logic       dout;
  logic       busy;
  logic       frame_done;
  logic [7:0] mem [0:3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  everloop_tx #(
    .N_BYTES(N_BYTES), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
    .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  int         rise_q[$];
  int         hi_q[$];
  int         fd_q[$];
  int         bfall_q[$];
  int         brise_q[$];
  logic [7:0] rd_q[$];
  int         rd_wide = 0;
  int         hi_cnt = 0;
  logic       dout_prev = 1'b0;
  logic       busy_prev = 1'b0;
  logic       rd_prev = 1'b0;

  always @(negedge clk) begin
    if (dout && !dout_prev) rise_q.push_back(cyc);
    if (dout) hi_cnt <= dout_prev ? hi_cnt + 1 : 1;
    if (!dout && dout_prev) hi_q.push_back(hi_cnt);
    if (ram_rd) rd_q.push_back(ram_addr);
    if (ram_rd && rd_prev) rd_wide <= rd_wide + 1;
    if (frame_done) fd_q.push_back(cyc);
    if (busy && !busy_prev) brise_q.push_back(cyc);
    if (!busy && busy_prev) bfall_q.push_back(cyc);
    dout_prev <= dout;
    busy_prev <= busy;
    rd_prev   <= ram_rd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rises(input int n, input int limit);
    int k = 0;
    while (rise_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    check($sformatf("wait_rise%0d", n), 32'(rise_q.size() >= n), 32'd1);
  endtask

  task automatic wait_fd(input int n, input int limit);
    int k = 0;
    while (fd_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    check($sformatf("wait_fd%0d", n), 32'(fd_q.size() >= n), 32'd1);
  endtask

  // Decodes 32 high widths starting at pulse index b and checks cell spacing.
  task automatic check_frame(input int b, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input string tag);
    logic [7:0] exp_b [4];
    logic [7:0] got;
    int bad_w;
    int bad_sp;
    int w;
    exp_b = '{e0, e1, e2, e3};
    bad_w = 0;
    bad_sp = 0;
    for (int j = 0; j < 4; j++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        w = hi_q[b + 8*j + i];
        got = {got[6:0], (w == T1H)};
        if (w != T1H && w != T0H) bad_w++;
      end
      check($sformatf("%s_byte%0d", tag, j), 32'(got), 32'(exp_b[j]));
    end
    for (int i = 1; i < 32; i++)
      if (rise_q[b + i] - rise_q[b + i - 1] != T_BIT) bad_sp++;
    check({tag, "_bad_widths"}, bad_w, 0);
    check({tag, "_bad_spacing"}, bad_sp, 0);
    for (int j = 1; j < 4; j++)
      check($sformatf("%s_boundary%0d", tag, j), rise_q[b + 8*j] - rise_q[b + 8*j - 1], T_BIT);
  endtask

  int t_en;
  int nr;
  int nrd;

  initial begin
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h3C;

    // reset state
    repeat (3) tick();
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_ram_addr", ram_addr, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single frame from a one-cycle en pulse
    en = 1'b1;
    t_en = cyc + 1;
    tick();
    en = 1'b0;
    wait_fd(1, 600);
    repeat (40) tick();
    check("f1_latency", rise_q[0] - t_en, 3);
    check("f1_busy_rise", brise_q[0] - t_en, 1);
    check("f1_rises", rise_q.size(), 32);
    check_frame(0, 8'hA5, 8'h00, 8'hFF, 8'h3C, "f1");
    check("f1_reads", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("f1_rd_addr%0d", i), rd_q[i], i);
    check("f1_fd_count", fd_q.size(), 1);
    check("f1_latch", fd_q[0] - rise_q[31], T_BIT - 1 + T_RESET);
    check("f1_busy_fall", bfall_q[0] - fd_q[0], 1);
    check("f1_idle_busy", busy, 0);

    // continuous mode; rewrite byte 1 in the latch gap, drop en during byte 2 of frame 3
    en = 1'b1;
    t_en = cyc + 1;
    wait_rises(64, 800);
    repeat (15) tick();
    mem[1] = 8'h81;
    wait_rises(82, 800);
    en = 1'b0;
    wait_fd(3, 800);
    repeat (50) tick();
    check("f2_latency", rise_q[32] - t_en, 3);
    check_frame(32, 8'hA5, 8'h00, 8'hFF, 8'h3C, "f2");
    check_frame(64, 8'hA5, 8'h81, 8'hFF, 8'h3C, "f3");
    check("cont_rises", rise_q.size(), 96);
    check("cont_fd_count", fd_q.size(), 3);
    check("cont_reads", rd_q.size(), 12);
    for (int i = 4; i < 12; i++) check($sformatf("cont_rd_addr%0d", i), rd_q[i], i % 4);
    check("f2_latch", fd_q[1] - rise_q[63], T_BIT - 1 + T_RESET);
    check("f3_restart", rise_q[64] - fd_q[1], 3);
    check("f3_latch", fd_q[2] - rise_q[95], T_BIT - 1 + T_RESET);
    check("cont_busy_falls", bfall_q.size(), 2);
    check("f3_busy_fall", bfall_q[1] - fd_q[2], 1);
    check("rd_single_cycle", rd_wide, 0);
    check("cont_idle_dout", dout, 0);

    // asynchronous reset while dout is high in a '1' cell
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_rises(97, 50);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_busy", busy, 0);
    check("arst_ram_rd", ram_rd, 0);
    check("arst_ram_addr", ram_addr, 0);
    check("arst_frame_done", frame_done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    nr = rise_q.size();
    nrd = rd_q.size();
    repeat (30) tick();
    check("post_rst_rises", rise_q.size(), nr);
    check("post_rst_reads", rd_q.size(), nrd);
    check("post_rst_busy", busy, 0);
    en = 1'b1;
    t_en = cyc + 1;
    tick();
    en = 1'b0;
    wait_rises(nr + 1, 20);
    check("post_rst_latency", rise_q[nr] - t_en, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
